// File: rtl/timer_pkg.sv
// Shared CPU definitions for the memory-mapped timer.
// Holds the decoded register addresses, TCON bit positions and the address
// decode helper, so the bus decoder and the timer agree on one map.
package timer_pkg;

    localparam logic [31:0] ADDR_TH   = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL   = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON = 32'h4000_0008;
    localparam logic [31:0] ADDR_PRE  = 32'h4000_000C;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;
    localparam int TCON_OS = 3;

    localparam int PRE_W = 16;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_TH,
        REG_TL,
        REG_TCON,
        REG_PRE
    } reg_sel_t;

    // Full 32-bit compare: anything outside the four words selects nothing.
    function automatic reg_sel_t decode_addr(input logic [31:0] addr);
        reg_sel_t sel;
        case (addr)
            ADDR_TH:   sel = REG_TH;
            ADDR_TL:   sel = REG_TL;
            ADDR_TCON: sel = REG_TCON;
            ADDR_PRE:  sel = REG_PRE;
            default:   sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the timer.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   en         : count enable (TCON.EN); pc holds while low
//   clear      : force pc back to 0 (PRE or TCON written)
//   pre        : terminal count; a tick is produced every pre+1 enabled cycles
//   tick       : one-cycle pulse when pc reaches pre
module timer_prescaler
    import timer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [PRE_W-1:0] pre,
    output logic             tick
);

    logic [PRE_W-1:0] pc;

    // Tick comes from the current pc, so a clear in the same cycle still
    // lets this cycle's tick through; the clear only affects the next count.
    assign tick = en & (pc == pre);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
        end else if (clear) begin
            pc <= '0;
        end else if (en) begin
            pc <= tick ? '0 : pc + PRE_W'(1);
        end
    end

endmodule

// File: rtl/timer.sv
// Memory-mapped 32-bit up-counting timer with reload and interrupt.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   Addr       : CPU byte address; TH/TL/TCON/PRE decoded at 0x40000000..0C
//   WriteData  : store data
//   MemWr      : store strobe, one write per asserted cycle
//   MemRd      : load strobe
//   ReadData   : combinational load data, 0 when not reading a decoded word
//   IRQ        : level interrupt, IE & IS from registered state
module timer
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemWr,
    input  logic        MemRd,
    output logic [31:0] ReadData,
    output logic        IRQ
);

    logic [31:0]      th;
    logic [31:0]      tl;
    logic [PRE_W-1:0] pre;
    logic             tcon_en;
    logic             tcon_ie;
    logic             tcon_is;
    logic             tcon_os;

    reg_sel_t sel;
    logic     wr_th;
    logic     wr_tl;
    logic     wr_tcon;
    logic     wr_pre;
    logic     tick;
    logic     ovf;

    assign sel     = decode_addr(Addr);
    assign wr_th   = MemWr & (sel == REG_TH);
    assign wr_tl   = MemWr & (sel == REG_TL);
    assign wr_tcon = MemWr & (sel == REG_TCON);
    assign wr_pre  = MemWr & (sel == REG_PRE);

    // A CPU write to TL overrides the tick, so it also suppresses the
    // overflow side effects (reload, IS, one-shot stop).
    assign ovf = tick & (tl == 32'hFFFF_FFFF) & ~wr_tl;

    timer_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (tcon_en),
        .clear (wr_pre | wr_tcon),
        .pre   (pre),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            th  <= '0;
            tl  <= '0;
            pre <= '0;
        end else begin
            if (wr_th) begin
                th <= WriteData;
            end
            if (wr_pre) begin
                pre <= WriteData[PRE_W-1:0];
            end
            if (wr_tl) begin
                tl <= WriteData;
            end else if (tick) begin
                tl <= ovf ? th : tl + 32'd1;
            end
        end
    end

    // A TCON write takes every written bit, except that an overflow in the
    // same cycle still raises IS so the interrupt is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcon_en <= 1'b0;
            tcon_ie <= 1'b0;
            tcon_is <= 1'b0;
            tcon_os <= 1'b0;
        end else if (wr_tcon) begin
            tcon_en <= WriteData[TCON_EN];
            tcon_ie <= WriteData[TCON_IE];
            tcon_is <= WriteData[TCON_IS] | (ovf & tcon_ie);
            tcon_os <= WriteData[TCON_OS];
        end else begin
            if (ovf & tcon_ie) begin
                tcon_is <= 1'b1;
            end
            if (ovf & tcon_os) begin
                tcon_en <= 1'b0;
            end
        end
    end

    always_comb begin
        ReadData = '0;
        if (MemRd) begin
            case (sel)
                REG_TH:   ReadData = th;
                REG_TL:   ReadData = tl;
                REG_TCON: begin
                    ReadData[TCON_EN] = tcon_en;
                    ReadData[TCON_IE] = tcon_ie;
                    ReadData[TCON_IS] = tcon_is;
                    ReadData[TCON_OS] = tcon_os;
                end
                REG_PRE:  ReadData[PRE_W-1:0] = pre;
                default:  ReadData = '0;
            endcase
        end
    end

    assign IRQ = tcon_ie & tcon_is;

endmodule

// File: tb/tb_timer.sv
module tb_timer;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_PRE  = 32'h4000_000C;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        MemWr;
    logic        MemRd;
    logic [31:0] ReadData;
    logic        IRQ;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: architectural registers plus the number of enabled
    // cycles since the prescaler was last cleared.
    logic [31:0] m_th, m_tl;
    logic [15:0] m_pre;
    logic        m_en, m_ie, m_is, m_os;
    int          m_k;

    timer dut (
        .clk       (clk),
        .reset     (reset),
        .Addr      (Addr),
        .WriteData (WriteData),
        .MemWr     (MemWr),
        .MemRd     (MemRd),
        .ReadData  (ReadData),
        .IRQ       (IRQ)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (a)
            A_TH:    return m_th;
            A_TL:    return m_tl;
            A_TCON:  return {28'd0, m_os, m_is, m_ie, m_en};
            A_PRE:   return {16'd0, m_pre};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_update(input logic rst, input logic [31:0] a, input logic [31:0] d,
                                input logic wr);
        int   period;
        logic tick, ovf;
        if (rst) begin
            m_th = 0; m_tl = 0; m_pre = 0;
            m_en = 0; m_ie = 0; m_is = 0; m_os = 0;
            m_k = 0;
            return;
        end
        period = int'(m_pre) + 1;
        tick   = m_en && ((m_k % period) == period - 1);
        ovf    = tick && (m_tl == 32'hFFFF_FFFF) && !(wr && a == A_TL);
        if (wr && (a == A_PRE || a == A_TCON)) m_k = 0;
        else if (m_en) m_k = m_k + 1;
        if (wr && a == A_TL) m_tl = d;
        else if (ovf) m_tl = m_th;
        else if (tick) m_tl = m_tl + 1;
        if (wr && a == A_TCON) begin
            m_is = d[2] | (ovf & m_ie);
            m_en = d[0];
            m_ie = d[1];
            m_os = d[3];
        end else begin
            if (ovf && m_ie) m_is = 1;
            if (ovf && m_os) m_en = 0;
        end
        if (wr && a == A_TH)  m_th = d;
        if (wr && a == A_PRE) m_pre = d[15:0];
    endtask

    // One clock cycle: drive, check pre-edge outputs against the model,
    // advance the model, then return at the following falling edge.
    task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] d,
                        input logic wr, input logic rd);
        reset = rst; Addr = a; WriteData = d; MemWr = wr; MemRd = rd;
        #1;
        check("rdata", ReadData, rd ? model_read(a) : 32'd0);
        check("irq", {31'd0, IRQ}, {31'd0, m_ie & m_is});
        model_update(rst, a, d, wr);
        @(posedge clk);
        @(negedge clk);
        reset = 0; MemWr = 0; MemRd = 0; Addr = 0; WriteData = 0;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, a, d, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic read_now(input logic [31:0] a, output logic [31:0] v);
        Addr = a; MemRd = 1; MemWr = 0;
        #1;
        v = ReadData;
        MemRd = 0;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        read_now(a, v);
        check(tag, v, exp);
    endtask

    task automatic check_irq(input string tag, input logic exp);
        check(tag, {31'd0, IRQ}, {31'd0, exp});
    endtask

    initial begin
        logic [31:0] a, d;
        logic        wr, rd, rst;
        int          sel;

        reset = 1; Addr = 0; WriteData = 0; MemWr = 0; MemRd = 0;
        @(posedge clk);
        @(negedge clk);
        model_update(1'b1, 32'd0, 32'd0, 1'b0);
        step(1'b1, A_TL, 32'h1234, 1'b1, 1'b0);

        check_reg("rst_th", A_TH, 32'd0);
        check_reg("rst_tl", A_TL, 32'd0);
        check_reg("rst_tcon", A_TCON, 32'd0);
        check_reg("rst_pre", A_PRE, 32'd0);
        check_irq("rst_irq", 1'b0);

        // Reload after four ticks with PRE=0
        wr_reg(A_PRE, 32'd0);
        wr_reg(A_TH, 32'hFFFF_FFFC);
        wr_reg(A_TL, 32'hFFFF_FFFC);
        wr_reg(A_TCON, 32'h3);
        idle(3);
        check_reg("pre_ovf_tl", A_TL, 32'hFFFF_FFFF);
        check_irq("pre_ovf_irq", 1'b0);
        idle(1);
        check_reg("reload_tl", A_TL, 32'hFFFF_FFFC);
        check_irq("reload_irq", 1'b1);
        check_reg("reload_tcon", A_TCON, 32'h7);

        // Clearing IS, then clearing in the same cycle as an overflow
        wr_reg(A_TCON, 32'h3);
        check_irq("clr_irq", 1'b0);
        check_reg("clr_tl", A_TL, 32'hFFFF_FFFD);
        idle(2);
        wr_reg(A_TCON, 32'h3);
        check_irq("clr_ovf_irq", 1'b1);
        check_reg("clr_ovf_tl", A_TL, 32'hFFFF_FFFC);
        check_reg("clr_ovf_tcon", A_TCON, 32'h7);

        // PRE=2 counting, IE=0
        wr_reg(A_TCON, 32'h0);
        wr_reg(A_PRE, 32'd2);
        wr_reg(A_TL, 32'd0);
        wr_reg(A_TCON, 32'h1);
        idle(2);
        check_reg("pre2_tl0", A_TL, 32'd0);
        idle(1);
        check_reg("pre2_tl1", A_TL, 32'd1);
        idle(3);
        check_reg("pre2_tl2", A_TL, 32'd2);
        check_irq("pre2_irq", 1'b0);

        // TL write colliding with a tick
        wr_reg(A_PRE, 32'd0);
        wr_reg(A_TL, 32'h10);
        check_reg("tlwr_tick", A_TL, 32'h10);
        idle(1);
        check_reg("tlwr_next", A_TL, 32'h11);

        // One-shot
        wr_reg(A_TCON, 32'h0);
        wr_reg(A_TH, 32'h1234);
        wr_reg(A_TL, 32'hFFFF_FFFF);
        wr_reg(A_TCON, 32'hB);
        check_reg("os_arm_tl", A_TL, 32'hFFFF_FFFF);
        idle(1);
        check_reg("os_reload", A_TL, 32'h1234);
        check_reg("os_tcon", A_TCON, 32'hE);
        check_irq("os_irq", 1'b1);
        idle(3);
        check_reg("os_frozen", A_TL, 32'h1234);
        check_reg("os_tcon2", A_TCON, 32'hE);

        // Reset while counting with IRQ pending, racing a TL write
        wr_reg(A_TCON, 32'h7);
        idle(2);
        check_reg("run_tl", A_TL, 32'h1236);
        check_irq("run_irq", 1'b1);
        step(1'b1, A_TL, 32'h55, 1'b1, 1'b0);
        check_reg("rst2_th", A_TH, 32'd0);
        check_reg("rst2_tl", A_TL, 32'd0);
        check_reg("rst2_tcon", A_TCON, 32'd0);
        check_irq("rst2_irq", 1'b0);
        idle(3);
        check_reg("rst2_hold", A_TL, 32'd0);

        // Read+write together, undecoded writes, unused bits
        step(1'b0, A_TH, 32'hCAFE_F00D, 1'b1, 1'b1);
        check_reg("rw_th", A_TH, 32'hCAFE_F00D);
        wr_reg(32'h4000_0010, 32'h1);
        wr_reg(32'h0000_0008, 32'h1);
        wr_reg(32'h4000_0009, 32'h1);
        check_reg("undec_tcon", A_TCON, 32'd0);
        check_reg("undec_tl", A_TL, 32'd0);
        wr_reg(A_TCON, 32'hFFFF_FFF0);
        check_reg("mask_tcon", A_TCON, 32'd0);
        wr_reg(A_PRE, 32'hABCD_0003);
        check_reg("mask_pre", A_PRE, 32'd3);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 4);
            d   = $urandom;
            case (sel)
                0: a = A_TH;
                1: begin
                    a = A_TL;
                    if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - $urandom_range(0, 6);
                end
                2: a = A_TCON;
                3: begin
                    a = A_PRE;
                    d = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3);
                end
                default: a = ($urandom_range(0, 1) == 1) ? 32'h4000_0010 + 32'($urandom_range(0, 3) * 4)
                                                         : 32'h0000_0004;
            endcase
            wr  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 199) == 0);
            step(rst, a, d, wr, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 Addr  input  32  byte address from the CPU data path; only 0x40000000-0x4000000C are decoded.
REQ-004 WriteData  input  32  store data.
REQ-005 MemWr  input  1  store strobe from the Control unit; one write per asserted cycle.
REQ-006 MemRd  input  1  load strobe from the Control unit.
REQ-007 ReadData  output  32  load data, combinational from registers; 0 when MemRd=0 or address not decoded.
REQ-008 IRQ  output  1  level interrupt request to the Control unit; IRQ = TCON[1] & TCON[2], registered state only.

Function
REQ-009 Register map: 0x40000000 TH (32b reload), 0x40000004 TL (32b counter), 0x40000008 TCON (bits 3:0), 0x4000000C PRE (16b prescale); reads of unused TCON/PRE bits return 0.
REQ-010 TCON bits: [0] EN count enable, [1] IE interrupt enable, [2] IS interrupt status, [3] OS one-shot mode.
REQ-011 Tick: prescale counter PC counts 0..PRE while EN=1; tick asserts for one cycle when PC==PRE, then PC wraps to 0; PRE=0 gives a tick every cycle.
REQ-012 EN=0 holds PC and TL; writing PRE or TCON resets PC to 0.
REQ-013 On tick with TL != 0xFFFFFFFF: TL <= TL+1 (mod 2^32).
REQ-014 On tick with TL == 0xFFFFFFFF (overflow): TL <= TH; if IE=1, IS <= 1; if OS=1, EN <= 0 in the same cycle.
REQ-015 IS is sticky; only a TCON write with bit2=0 or reset clears it.
REQ-016 Simultaneous CPU write to TL and tick: the write wins and no increment/reload occurs that cycle.
REQ-017 Simultaneous TCON write clearing IS and overflow with IE=1: IS ends at 1 (no lost interrupt); the other written TCON bits still take effect.
REQ-018 Simultaneous TCON write and overflow with OS=1: the written EN value wins.
REQ-019 Write to TH does not affect TL until the next overflow.
REQ-020 Writes with MemWr=1 to undecoded addresses have no effect; MemRd and MemWr both high: write occurs, ReadData shows pre-write value.
REQ-021 Latency: a write is visible on ReadData the cycle after the MemWr edge; IRQ rises the cycle after the overflow edge.

Reset
REQ-022 reset=1 at a clock edge sets TH=0, TL=0, TCON=0, PRE=0, PC=0; IRQ=0 in the following cycle.
REQ-023 reset asserted mid-count or with IS pending discards all state; reset has priority over any same-cycle write or tick.

Structure
REQ-024 Register addresses and TCON bit indices are constants in the shared CPU definitions package, shared with the bus decoder.
REQ-025 The prescaler (PC, PRE compare, tick output, clear input) is one sub-module, timer_prescaler; the register file, counter and IRQ logic stay in timer.

Verification
REQ-026 PRE=0, TH=0xFFFFFFFC, TL=0xFFFFFFFC, TCON=0x3 -> TL reloads to 0xFFFFFFFC on the 4th cycle after enable; IRQ=1 the next cycle.
REQ-027 PRE=2, TL=0, TCON=0x1 -> TL=1 after 3 cycles, TL=2 after 6; IRQ stays 0 (IE=0).
REQ-028 IS=1 pending, TCON write 0x3 -> IRQ=0 next cycle; repeat with write in the same cycle as overflow -> IRQ remains 1.
REQ-029 TCON=0xB (one-shot), TL=0xFFFFFFFF, PRE=0 -> one reload to TH, EN reads 0, TL frozen thereafter.
REQ-030 Write TL=0x10 in the same cycle as a tick -> TL reads 0x10, not 0x11.
REQ-031 reset pulse while counting with IRQ=1 -> all registers read 0, IRQ=0, no count until TCON rewritten.
